// File: rtl/riscv_isa_pkg.sv
// Shared RV32I encoding constants, encoder FSM states and fault codes.
// U/J opcodes are always declared; their use is gated by UJ_FORMAT_EN in instr_packer.
package riscv_isa_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_SB    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [1:0] ERR_OPCODE = 2'b00;
   localparam logic [1:0] ERR_RANGE  = 2'b01;
   localparam logic [1:0] ERR_ALIGN  = 2'b10;
   localparam logic [1:0] ERR_OVF    = 2'b11;

   typedef enum logic [2:0] {StIdle, StEnc, StWrite, StDone, StError} state_e;

   // True when v[31:msb] are all equal, i.e. v fits a signed field whose sign bit is msb.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
      logic [31:0] mask;
      mask = 32'hffff_ffff << msb;
      return ((v & mask) == mask) || ((v & mask) == 32'h0);
   endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational RV32I field packer: fields + signed immediate -> {word, fault, code}.
// U/J formats (LUI, AUIPC, JAL) are only recognised when UJ_FORMAT_EN is defined.
module instr_packer
   import riscv_isa_pkg::*;
(
   input  logic [6:0]  opcode_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        fault_o,
   output logic [1:0]  code_o
);

   always_comb begin
      word_o  = 32'h0;
      fault_o = 1'b0;
      code_o  = ERR_OPCODE;
      case (opcode_i)
         OP_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         OP_I, OP_LOAD: begin
            word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            if (!fits_signed(imm_i, 11)) begin
               fault_o = 1'b1;
               code_o  = ERR_RANGE;
            end
         end
         OP_S: begin
            word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            if (!fits_signed(imm_i, 11)) begin
               fault_o = 1'b1;
               code_o  = ERR_RANGE;
            end
         end
         OP_SB: begin
            word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                      opcode_i};
            // Range fault outranks the alignment fault.
            if (!fits_signed(imm_i, 12)) begin
               fault_o = 1'b1;
               code_o  = ERR_RANGE;
            end else if (imm_i[0]) begin
               fault_o = 1'b1;
               code_o  = ERR_ALIGN;
            end
         end
`ifdef UJ_FORMAT_EN
         OP_LUI, OP_AUIPC: begin
            word_o = {imm_i[31:12], rd_i, opcode_i};
            if (imm_i[11:0] != 12'h0) begin
               fault_o = 1'b1;
               code_o  = ERR_RANGE;
            end
         end
         OP_JAL: begin
            word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            if (!fits_signed(imm_i, 20)) begin
               fault_o = 1'b1;
               code_o  = ERR_RANGE;
            end else if (imm_i[0]) begin
               fault_o = 1'b1;
               code_o  = ERR_ALIGN;
            end
         end
`endif
         default: begin
            fault_o = 1'b1;
            code_o  = ERR_OPCODE;
         end
      endcase
   end

endmodule

// File: rtl/imm_instr_encoder.sv
// Program loader: packs decoded fields into RV32I words and writes them to instruction memory.
// Define UJ_FORMAT_EN to also accept LUI/AUIPC/JAL.
module imm_instr_encoder
   import riscv_isa_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned DEPTH     = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W+1)'(DEPTH);

   state_e            state_q;
   logic [6:0]        op_q, f7_q;
   logic [4:0]        rd_q, rs1_q, rs2_q;
   logic [2:0]        f3_q;
   logic [31:0]       imm_q;
   logic              last_q;
   logic              we_q, done_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [ADDR_W:0]   count_q;
   logic [1:0]        code_q;

   logic [31:0] pk_word;
   logic        pk_fault;
   logic [1:0]  pk_code;
   logic        ovf;

   instr_packer u_packer (
      .opcode_i (op_q),
      .rd_i     (rd_q),
      .rs1_i    (rs1_q),
      .rs2_i    (rs2_q),
      .funct3_i (f3_q),
      .funct7_i (f7_q),
      .imm_i    (imm_q),
      .word_o   (pk_word),
      .fault_o  (pk_fault),
      .code_o   (pk_code)
   );

   // Word count tracks mem_addr - BASE_ADDR without wrapping when DEPTH fills the address space.
   assign ovf = (count_q == DepthCnt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= 7'h0;
         f7_q    <= 7'h0;
         rd_q    <= 5'h0;
         rs1_q   <= 5'h0;
         rs2_q   <= 5'h0;
         f3_q    <= 3'h0;
         imm_q   <= 32'h0;
         last_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= BaseAddr;
         wdata_q <= 32'h0;
         count_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_OPCODE;
      end else if (start) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         addr_q  <= BaseAddr;
         count_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_OPCODE;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  op_q    <= in_opcode;
                  f7_q    <= in_funct7;
                  rd_q    <= in_rd;
                  rs1_q   <= in_rs1;
                  rs2_q   <= in_rs2;
                  f3_q    <= in_funct3;
                  imm_q   <= in_imm;
                  last_q  <= in_last;
                  state_q <= StEnc;
               end
            end
            StEnc: begin
               if (ovf || pk_fault) begin
                  state_q <= StError;
                  err_q   <= 1'b1;
                  code_q  <= ovf ? ERR_OVF : pk_code;
               end else begin
                  state_q <= StWrite;
                  we_q    <= 1'b1;
                  wdata_q <= pk_word;
               end
            end
            StWrite: begin
               if (mem_ready) begin
                  we_q    <= 1'b0;
                  addr_q  <= addr_q + 1'b1;
                  count_q <= count_q + 1'b1;
                  if (last_q) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StDone, StError: ;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle) && !start;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign count     = count_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_code  = code_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Self-checking bench for imm_instr_encoder: directed steps followed by randomized bundles
// checked against an arithmetic model of RV32I encoding.
module tb_imm_instr_encoder;

   localparam int unsigned AW  = 8;
   localparam int unsigned DEP = 4;
`ifdef UJ_FORMAT_EN
   localparam bit UjEn = 1'b1;
`else
   localparam bit UjEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start, in_valid, in_ready, in_last;
   logic [6:0]    in_opcode, in_funct7;
   logic [4:0]    in_rd, in_rs1, in_rs2;
   logic [2:0]    in_funct3;
   logic [31:0]   in_imm, mem_wdata;
   logic          mem_we, mem_ready, done, err;
   logic [AW-1:0] mem_addr;
   logic [AW:0]   count;
   logic [1:0]    err_code;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          exp_addr, exp_count;
   bit          exp_done, exp_err;
   logic [31:0] obs_word, w0;

   imm_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(DEP)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .in_last   (in_last),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .count     (count),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference encoder: masks and shifts on the integer immediate, range tests as signed compares.
   function automatic void model(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input int imm, input int cnt, output logic [31:0] w,
                                 output bit flt, output logic [1:0] code);
      logic [31:0] u, regs;
      u    = imm;
      regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
      w    = 32'h0;
      flt  = 1'b0;
      code = 2'd0;
      if (op == 7'h33) begin
         w = (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'(op);
      end else if (op == 7'h13 || op == 7'h03) begin
         w = ((u & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
         if (imm < -2048 || imm > 2047) begin flt = 1'b1; code = 2'd1; end
      end else if (op == 7'h23) begin
         w = (((u >> 5) & 32'h7f) << 25) | regs | ((u & 32'h1f) << 7) | 32'(op);
         if (imm < -2048 || imm > 2047) begin flt = 1'b1; code = 2'd1; end
      end else if (op == 7'h63) begin
         w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | regs |
             (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | 32'(op);
         if (imm < -4096 || imm > 4095) begin flt = 1'b1; code = 2'd1; end
         else if ((imm % 2) != 0) begin flt = 1'b1; code = 2'd2; end
      end else if (UjEn && (op == 7'h37 || op == 7'h17)) begin
         w = (u & 32'hffff_f000) | (32'(rd) << 7) | 32'(op);
         if ((u & 32'hfff) != 0) begin flt = 1'b1; code = 2'd1; end
      end else if (UjEn && op == 7'h6f) begin
         w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) | (((u >> 11) & 1) << 20) |
             (((u >> 12) & 32'hff) << 12) | (32'(rd) << 7) | 32'(op);
         if (imm < -1048576 || imm > 1048575) begin flt = 1'b1; code = 2'd1; end
         else if ((imm % 2) != 0) begin flt = 1'b1; code = 2'd2; end
      end else begin
         flt  = 1'b1;
         code = 2'd0;
      end
      if (cnt == int'(DEP)) begin
         flt  = 1'b1;
         code = 2'd3;
      end
   endfunction

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      #1 chk("in_ready_in_start", in_ready, 1'b0);
      @(negedge clk);
      start     = 1'b0;
      exp_addr  = 0;
      exp_count = 0;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      chk("start_done", done, 1'b0);
      chk("start_err", err, 1'b0);
      chk("start_count", count, 0);
      chk("start_addr", mem_addr, 0);
      chk("start_we", mem_we, 1'b0);
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input int imm, input bit last, input int stall);
      logic [31:0] w;
      bit          flt;
      logic [1:0]  code;
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1'b1);
      in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
      in_valid  = 1'b1;
      mem_ready = (stall == 0);
      @(negedge clk);
      in_valid = 1'b0;
      model(op, rd, rs1, rs2, f3, f7, imm, exp_count, w, flt, code);
      @(negedge clk);
      if (flt) begin
         chk("err_flag", err, 1'b1);
         chk("err_code", err_code, code);
         chk("no_write", mem_we, 1'b0);
         chk("err_addr_held", mem_addr, exp_addr);
         exp_err = 1'b1;
      end else begin
         chk("we", mem_we, 1'b1);
         chk("addr", mem_addr, exp_addr);
         chk("wdata", mem_wdata, w);
         obs_word = mem_wdata;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_we", mem_we, 1'b1);
            chk("stall_addr", mem_addr, exp_addr);
            chk("stall_wdata", mem_wdata, w);
            chk("stall_count", count, exp_count);
         end
         mem_ready = 1'b1;
         @(negedge clk);
         exp_addr++;
         exp_count++;
         chk("we_drop", mem_we, 1'b0);
         chk("addr_inc", mem_addr, exp_addr % 256);
         chk("count", count, exp_count);
         chk("done", done, last);
         exp_done = last;
      end
   endtask

   initial begin
      logic [6:0] ops [10];
      int         imm;
      int         mode;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h0f, 7'h7f};
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
      in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;
      in_imm = '0;
      exp_addr = 0; exp_count = 0; exp_done = 1'b0; exp_err = 1'b0; obs_word = '0; w0 = '0;
      #12;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_count", count, 0);
      chk("rst_flags", {done, err, err_code}, 4'b0);
      reset = 1'b0;

      // addi x1,x0,5
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5, 1'b1, 0);
      chk("addi_word", obs_word, 32'h0050_0093);
      @(negedge clk);
      chk("done_sticky", done, 1'b1);
      chk("done_in_ready", in_ready, 1'b0);

      // sw x2,8(x1); beq x1,x2,-4
      do_start();
      send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 8, 1'b0, 0);
      w0 = obs_word;
      chk("sw_word", w0, 32'h0020_A423);
      send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -4, 1'b1, 0);
      chk("beq_word", obs_word, 32'hFE20_8EE3);
      chk("two_count", count, 2);

      // range / alignment faults
      do_start();
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048, 1'b0, 0);
      do_start();
      send(7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 6, 1'b0, 0);
      send(7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 3, 1'b0, 0);

      // memory overflow: DEPTH words then a fault
      do_start();
      for (int i = 0; i < 5; i++) send(7'h13, 5'(i), 5'd2, 5'd0, 3'd0, 7'd0, i, 1'b0, 0);
      chk("ovf_addr", mem_addr, DEP);

      // stalled write
      do_start();
      send(7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 0, 1'b0, 5);

      // start together with in_valid in IDLE
      @(negedge clk);
      in_valid = 1'b1; start = 1'b1;
      #1 chk("start_blocks_ready", in_ready, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; start = 1'b0;
      exp_addr = 0; exp_count = 0;
      @(negedge clk);
      @(negedge clk);
      chk("start_nowrite", mem_we, 1'b0);
      chk("start_still_idle", in_ready, 1'b1);
      chk("start_count0", count, 0);

      // start abandons a write in progress
      @(negedge clk);
      in_opcode = 7'h13; in_rd = 5'd9; in_rs1 = 5'd1; in_imm = 32'd7; in_last = 1'b0;
      in_valid = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("abort_we_up", mem_we, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; mem_ready = 1'b1;
      chk("abort_we_drop", mem_we, 1'b0);
      chk("abort_count", count, 0);
      chk("abort_addr", mem_addr, 0);

      // unknown opcode, then JAL
      send(7'h0f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 0, 1'b0, 0);
      do_start();
      send(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048, 1'b0, 0);
`ifdef UJ_FORMAT_EN
      chk("jal_word", obs_word, 32'h0010_00EF);
`endif

      // randomized bundles
      for (int n = 0; n < 80; n++) begin
         if (exp_done || exp_err) do_start();
         mode = int'($urandom_range(3));
         case (mode)
            0: imm = int'($urandom_range(10000)) - 5000;
            1: imm = int'($urandom);
            2: imm = int'($urandom_range(4096)) - 2048;
            default: imm = int'($urandom_range(4_000_000)) - 2_000_000;
         endcase
         if ($urandom_range(3) == 0) imm = imm & ~32'hfff;
         send(ops[$urandom_range(9)], 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
              7'($urandom), imm, ($urandom_range(5) == 0), int'($urandom_range(2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
